hazard_ctrl: RTL

- Consumer-side control for the ID/EX pipeline register.
- Reads the EX-stage copy of the instruction and its control bits, compares them against the instruction in ID, and drives stall, bubble and flush controls back into PC, IF/ID and ID/EX.
- Handles load-use stalls (configurable length) and taken-branch flushes (configurable length).
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_ctrl_sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and instruction field positions for the ID/EX hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    localparam logic [5:0] OP_LW = 6'b100011;

    // Reserved branch encoding 11 never redirects the PC.
    function automatic logic branch_taken(input logic [1:0] br, input logic zero);
        logic taken;
        case (br)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count qualifying cycles, clearing first and never wrapping past all-ones.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush control for the ID/EX boundary, with
// saturating stall/flush performance counters. Controls are Mealy outputs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int CNT_W               = 4,
    parameter int PERF_W              = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ID_Instruction_In,
    input  logic [31:0]       EX_Instruction_In,
    input  logic              EX_MemRead_In,
    input  logic [1:0]        EX_Branch_In,
    input  logic              EX_Zero_In,
    output logic              PCWrite_Out,
    output logic              IFID_Write_Out,
    output logic              IFID_Flush_Out,
    output logic              IDEX_Bubble_Out,
    output logic [1:0]        State_Out,
    output logic [PERF_W-1:0] Stall_Count_Out,
    output logic [PERF_W-1:0] Flush_Count_Out
);

    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_REM_C = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_REM_C = CNT_W'(BRANCH_FLUSH_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] remain_r;
    logic [CNT_W-1:0] remain_nxt_s;

    logic [4:0] id_rs_s;
    logic [4:0] id_rt_s;
    logic [4:0] ex_rt_s;
    logic       load_use_s;
    logic       br_taken_s;

    logic       pc_write_s;
    logic       ifid_write_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;
    logic [1:0] state_out_s;

    assign id_rs_s    = ID_Instruction_In[RS_HI:RS_LO];
    assign id_rt_s    = ID_Instruction_In[RT_HI:RT_LO];
    assign ex_rt_s    = EX_Instruction_In[RT_HI:RT_LO];
    assign load_use_s = EX_MemRead_In && (ex_rt_s != 5'd0) &&
                        ((ex_rt_s == id_rs_s) || (ex_rt_s == id_rt_s));
    assign br_taken_s = branch_taken(EX_Branch_In, EX_Zero_In);

    // Next state and pipeline controls; branch wins over load-use, and while
    // a stall or flush is in progress EX holds a bubble so new hazards are ignored.
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        state_out_s   = ST_RUN;
        state_nxt_s   = ST_RUN;
        remain_nxt_s  = {CNT_W{1'b0}};
        if (reset) begin
            case (state_r)
                ST_RUN: begin
                    if (br_taken_s) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        if (BRANCH_FLUSH_CYCLES > 1) begin
                            state_nxt_s  = ST_FLUSH;
                            remain_nxt_s = FLUSH_REM_C;
                        end else begin
                            state_nxt_s  = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt_s  = ST_STALL;
                            remain_nxt_s = STALL_REM_C;
                        end else begin
                            state_nxt_s  = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_STALL: begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_bubble_s = 1'b1;
                    state_out_s   = ST_STALL;
                    if (remain_r == ONE_C) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s  = ST_STALL;
                        remain_nxt_s = remain_r - ONE_C;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    state_out_s   = ST_FLUSH;
                    if (remain_r == ONE_C) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s  = ST_FLUSH;
                        remain_nxt_s = remain_r - ONE_C;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State and remaining-cycle registers; reset abandons any stall or flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            remain_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            remain_r <= remain_nxt_s;
        end
    end

    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (~pc_write_s),
        .count (Stall_Count_Out)
    );

    sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (ifid_flush_s),
        .count (Flush_Count_Out)
    );

    assign PCWrite_Out     = pc_write_s;
    assign IFID_Write_Out  = ifid_write_s;
    assign IFID_Flush_Out  = ifid_flush_s;
    assign IDEX_Bubble_Out = idex_bubble_s;
    assign State_Out       = state_out_s;

endmodule
